// File: rtl/iteration_sequencer_if.sv
// Handshake bundle between the iteration sequencer and its controller/datapath.
// The abort input exists only when SEQ_ABORT_EN is defined.
interface iteration_sequencer_if #(
    parameter int NBITS = 8
);
    logic             start;
    logic             hold;
    logic             ack;
`ifdef SEQ_ABORT_EN
    logic             abort;
`endif
    logic [NBITS-1:0] count;
    logic             first;
    logic             advance;
    logic             flag;
    logic             busy;
    logic             done;

    modport master (
`ifdef SEQ_ABORT_EN
        output abort,
`endif
        output start, hold, ack,
        input  count, first, advance, flag, busy, done
    );

    modport slave (
`ifdef SEQ_ABORT_EN
        input  abort,
`endif
        input  start, hold, ack,
        output count, first, advance, flag, busy, done
    );
endinterface

// File: rtl/iteration_sequencer.sv
// Up-counting iteration sequencer (0 -> LIMIT by STEP) with start/busy/done handshake.
// Optional feature macro: SEQ_ABORT_EN adds an abort input that cancels a run.
module iteration_sequencer #(
    parameter int NBITS = 8,
    parameter int LIMIT = 8,
    parameter int STEP  = 2
) (
    input logic                  clk,
    input logic                  reset,
    iteration_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [NBITS-1:0] r_count;
    logic             r_first;
    logic             r_busy;
    logic             r_done;

    logic             w_run;
    logic [NBITS:0]   w_next_sum;
    logic             w_flag;
    logic             w_advance;
    logic             w_abort;

`ifdef SEQ_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // One extra bit so count + STEP can never wrap before the terminal compare.
    assign w_run      = (r_state == S_RUN);
    assign w_next_sum = {1'b0, r_count} + (NBITS + 1)'(STEP);
    assign w_flag     = w_run && (w_next_sum >= (NBITS + 1)'(LIMIT));
    assign w_advance  = w_run && !bus.hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_first <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_first <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_first <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (!bus.hold) begin
                        r_first <= 1'b0;
                        if (w_flag) begin
                            // Clamp so a non-multiple LIMIT still ends exactly on LIMIT.
                            r_state <= S_DONE;
                            r_count <= NBITS'(LIMIT);
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= w_next_sum[NBITS-1:0];
                        end
                    end
                end
                S_DONE: begin
                    if (bus.ack) begin
                        r_count <= '0;
                        r_done  <= 1'b0;
                        if (bus.start) begin
                            r_state <= S_RUN;
                            r_first <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_first <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count   = r_count;
    assign bus.first   = r_first;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.flag    = w_flag;
    assign bus.advance = w_advance;
endmodule
